// File: rtl/entry_point_scheduler_pkg.sv
// Shared types and defaults for the entry-point scheduler: FSM state encoding,
// default bus widths and a small index-width helper.
package entry_point_scheduler_pkg;

  localparam int DEF_ROM_ADDRESS_WIDTH = 16;
  localparam int DEF_INSTRUCTION_WIDTH = 64;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_FETCH     = 2'd1,
    ST_WAIT_DATA = 2'd2,
    ST_RUN       = 2'd3
  } eps_state_t;

  // Width of a requester index; never narrower than one bit.
  function automatic int id_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/entry_point_scheduler_if.sv
// Requester / instruction-memory / IFU signal bundle of the entry-point scheduler.
interface entry_point_scheduler_if
  import entry_point_scheduler_pkg::*;
#(
  parameter int NUM_REQ           = 4,
  parameter int ROM_ADDRESS_WIDTH = DEF_ROM_ADDRESS_WIDTH,
  parameter int INSTRUCTION_WIDTH = DEF_INSTRUCTION_WIDTH
) ();
  localparam int IW = id_width(NUM_REQ);

  // Handshakes: iRequest[i] is a level held until its one-cycle oGrant[i]
  // pulse; iIMemData is valid exactly one cycle after oIMemRead, and
  // oIMemAddr is only meaningful while oIMemRead is high; oTriggerIFU,
  // oDone, oTimeout and oBadVector are single-cycle pulses; iIFUDone is
  // only observed while a job runs.
  logic [NUM_REQ-1:0]                   iRequest;
  logic [NUM_REQ*ROM_ADDRESS_WIDTH-1:0] iVectorAddr;
  logic [NUM_REQ-1:0]                   oGrant;
  logic                                 oIMemRead;
  logic [ROM_ADDRESS_WIDTH-1:0]         oIMemAddr;
  logic [INSTRUCTION_WIDTH-1:0]         iIMemData;
  logic [ROM_ADDRESS_WIDTH-1:0]         oEntryPoint;
  logic                                 oTriggerIFU;
  logic                                 iIFUDone;
  logic [NUM_REQ-1:0]                   oDone;
  logic                                 oTimeout;
  logic                                 oBadVector;
  logic                                 oBusy;
  logic [IW-1:0]                        oActiveId;
  eps_state_t                           oDbgState;

  modport slave (
    input  iRequest, iVectorAddr, iIMemData, iIFUDone,
    output oGrant, oIMemRead, oIMemAddr, oEntryPoint, oTriggerIFU,
           oDone, oTimeout, oBadVector, oBusy, oActiveId, oDbgState
  );

  modport master (
    output iRequest, iVectorAddr, iIMemData, iIFUDone,
    input  oGrant, oIMemRead, oIMemAddr, oEntryPoint, oTriggerIFU,
           oDone, oTimeout, oBadVector, oBusy, oActiveId, oDbgState
  );

endinterface

// File: rtl/entry_point_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first set request scanning upward from
// i_ptr+1 with wrap-around; returns a one-hot grant and the winner index.
module entry_point_scheduler_rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_idx,
  output logic          o_valid
);
  int w_j;

  // Scan from the farthest position back to the nearest so the nearest wins.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    w_j     = 0;
    for (int k = N; k >= 1; k--) begin
      w_j = (int'(i_ptr) + k) % N;
      if (i_req[w_j]) begin
        o_grant      = '0;
        o_grant[w_j] = 1'b1;
        o_idx        = IW'(w_j);
        o_valid      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/entry_point_scheduler.sv
// Entry-point scheduler: round-robin owner selection, entry-vector fetch from
// instruction memory, IFU launch and run supervision with a watchdog.
module entry_point_scheduler
  import entry_point_scheduler_pkg::*;
#(
  parameter int NUM_REQ           = 4,
  parameter int ROM_ADDRESS_WIDTH = DEF_ROM_ADDRESS_WIDTH,
  parameter int INSTRUCTION_WIDTH = DEF_INSTRUCTION_WIDTH,
  parameter int TIMEOUT           = 1024
) (
  input  logic                    Clock,
  input  logic                    Reset,
  entry_point_scheduler_if.slave  bus
);
  localparam int IW = id_width(NUM_REQ);
  localparam int WW = $clog2(TIMEOUT);
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);
  localparam int AW = ROM_ADDRESS_WIDTH;

  eps_state_t          r_state,  w_state_nxt;
  logic [IW-1:0]       r_ptr,    w_ptr_nxt;
  logic [IW-1:0]       r_active, w_active_nxt;
  logic [AW-1:0]       r_addr,   w_addr_nxt;
  logic [AW-1:0]       r_entry,  w_entry_nxt;
  logic [WW-1:0]       r_wd,     w_wd_nxt;
  logic [NUM_REQ-1:0]  r_grant,  w_grant_nxt;
  logic [NUM_REQ-1:0]  r_done,   w_done_nxt;
  logic                r_read,   w_read_nxt;
  logic                r_trig,   w_trig_nxt;
  logic                r_tmo,    w_tmo_nxt;
  logic                r_bad,    w_bad_nxt;

  logic [NUM_REQ-1:0]  w_arb_grant;
  logic [IW-1:0]       w_arb_idx;
  logic                w_arb_valid;
  logic [AW-1:0]       w_vec_addr;
  logic [AW-1:0]       w_fetched;

  entry_point_scheduler_rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_arb (
    .i_req   (bus.iRequest),
    .i_ptr   (r_ptr),
    .o_grant (w_arb_grant),
    .o_idx   (w_arb_idx),
    .o_valid (w_arb_valid)
  );

  assign w_vec_addr = bus.iVectorAddr[int'(w_arb_idx)*AW +: AW];
  assign w_fetched  = bus.iIMemData[AW-1:0];

  always_comb begin
    w_state_nxt  = r_state;
    w_ptr_nxt    = r_ptr;
    w_active_nxt = r_active;
    w_addr_nxt   = r_addr;
    w_entry_nxt  = r_entry;
    w_wd_nxt     = r_wd;
    w_grant_nxt  = '0;
    w_done_nxt   = '0;
    w_read_nxt   = 1'b0;
    w_trig_nxt   = 1'b0;
    w_tmo_nxt    = 1'b0;
    w_bad_nxt    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_arb_valid) begin
          w_state_nxt  = ST_FETCH;
          w_active_nxt = w_arb_idx;
          w_addr_nxt   = w_vec_addr;
          w_read_nxt   = 1'b1;
          w_grant_nxt  = w_arb_grant;
        end
      end
      ST_FETCH: w_state_nxt = ST_WAIT_DATA;
      ST_WAIT_DATA: begin
        // A zero entry point means the requester never installed a program.
        if (w_fetched == '0) begin
          w_bad_nxt   = 1'b1;
          w_ptr_nxt   = r_active;
          w_state_nxt = ST_IDLE;
        end else begin
          w_entry_nxt = w_fetched;
          w_trig_nxt  = 1'b1;
          w_wd_nxt    = '0;
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        // Done is checked first so it wins over a coincident watchdog expiry.
        if (bus.iIFUDone) begin
          w_done_nxt[r_active] = 1'b1;
          w_ptr_nxt            = r_active;
          w_entry_nxt          = '0;
          w_state_nxt          = ST_IDLE;
        end else if (r_wd == WD_LAST) begin
          w_tmo_nxt   = 1'b1;
          w_ptr_nxt   = r_active;
          w_entry_nxt = '0;
          w_state_nxt = ST_IDLE;
        end else begin
          w_wd_nxt = r_wd + 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_state  <= ST_IDLE;
      r_ptr    <= IW'(NUM_REQ - 1);
      r_active <= '0;
      r_addr   <= '0;
      r_entry  <= '0;
      r_wd     <= '0;
      r_grant  <= '0;
      r_done   <= '0;
      r_read   <= 1'b0;
      r_trig   <= 1'b0;
      r_tmo    <= 1'b0;
      r_bad    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_ptr    <= w_ptr_nxt;
      r_active <= w_active_nxt;
      r_addr   <= w_addr_nxt;
      r_entry  <= w_entry_nxt;
      r_wd     <= w_wd_nxt;
      r_grant  <= w_grant_nxt;
      r_done   <= w_done_nxt;
      r_read   <= w_read_nxt;
      r_trig   <= w_trig_nxt;
      r_tmo    <= w_tmo_nxt;
      r_bad    <= w_bad_nxt;
    end
  end

  assign bus.oGrant      = r_grant;
  assign bus.oIMemRead   = r_read;
  assign bus.oIMemAddr   = r_addr;
  assign bus.oEntryPoint = r_entry;
  assign bus.oTriggerIFU = r_trig;
  assign bus.oDone       = r_done;
  assign bus.oTimeout    = r_tmo;
  assign bus.oBadVector  = r_bad;
  assign bus.oBusy       = (r_state != ST_IDLE);
  assign bus.oActiveId   = r_active;
  assign bus.oDbgState   = r_state;

endmodule

// File: tb/tb_entry_point_scheduler.sv
// Self-checking bench for entry_point_scheduler: directed scenarios plus
// randomized jobs checked against a job-level round-robin model.
module tb_entry_point_scheduler;
  import entry_point_scheduler_pkg::*;

  localparam int N  = 4;
  localparam int AW = 16;
  localparam int DW = 64;
  localparam int TO = 8;

  logic Clock = 1'b0;
  logic Reset = 1'b0;
  always #5 Clock = ~Clock;

  entry_point_scheduler_if #(.NUM_REQ(N), .ROM_ADDRESS_WIDTH(AW), .INSTRUCTION_WIDTH(DW)) bus ();

  entry_point_scheduler #(
    .NUM_REQ(N), .ROM_ADDRESS_WIDTH(AW), .INSTRUCTION_WIDTH(DW), .TIMEOUT(TO)
  ) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  // Instruction memory: data appears one cycle after the read strobe, noise otherwise.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge Clock) begin
    if (bus.oIMemRead) bus.iIMemData <= mem[bus.oIMemAddr];
    else               bus.iIMemData <= {$urandom, $urandom};
  end

  int n_cmp = 0;
  int n_err = 0;
  int m_ptr;
  logic [N-1:0] pending;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Round-robin rule: first requester after the last owner, wrapping.
  function automatic int pick(input logic [N-1:0] req, input int ptr);
    for (int k = 1; k <= N; k++)
      if (req[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  task automatic check_quiet(input string tag);
    check_eq({tag, "_grant"}, bus.oGrant, 0);
    check_eq({tag, "_read"},  bus.oIMemRead, 0);
    check_eq({tag, "_entry"}, bus.oEntryPoint, 0);
    check_eq({tag, "_trig"},  bus.oTriggerIFU, 0);
    check_eq({tag, "_done"},  bus.oDone, 0);
    check_eq({tag, "_tmo"},   bus.oTimeout, 0);
    check_eq({tag, "_bad"},   bus.oBadVector, 0);
    check_eq({tag, "_busy"},  bus.oBusy, 0);
  endtask

  // One job from request to completion. done_at: RUN cycle (0 = trigger cycle)
  // in which iIFUDone is high; abort_at >= 0 pulls reset in that RUN cycle.
  task automatic run_job(input logic [N-1:0] new_req, input bit keep, input int done_at,
                         input int abort_at, input logic [AW-1:0] waddr, input logic [DW-1:0] wdata);
    int win;
    int end_c;
    logic [N-1:0] g;
    logic [AW-1:0] e;
    pending = pending | new_req;
    win = pick(pending, m_ptr);
    if (win < 0) begin
      check_eq("no_requester", 1, 0);
      return;
    end
    for (int i = 0; i < N; i++)
      bus.iVectorAddr[i*AW +: AW] = (i == win) ? waddr : AW'($urandom);
    mem[waddr] = wdata;
    bus.iRequest = pending;
    bus.iIFUDone = 1'($urandom_range(0, 1));
    g = '0;
    g[win] = 1'b1;
    e = wdata[AW-1:0];

    @(negedge Clock);
    check_eq("grant", bus.oGrant, g);
    check_eq("read", bus.oIMemRead, 1);
    check_eq("addr", bus.oIMemAddr, waddr);
    check_eq("active_id", bus.oActiveId, win);
    check_eq("busy_fetch", bus.oBusy, 1);
    check_eq("no_stale_pulse", {bus.oDone, bus.oTimeout, bus.oBadVector, bus.oTriggerIFU}, 0);
    if (!keep) pending[win] = 1'b0;
    bus.iRequest = pending;
    bus.iIFUDone = 1'($urandom_range(0, 1));

    @(negedge Clock);
    check_eq("grant_drop", bus.oGrant, 0);
    check_eq("read_drop", bus.oIMemRead, 0);
    check_eq("state_wait", bus.oDbgState, ST_WAIT_DATA);
    bus.iIFUDone = 1'($urandom_range(0, 1));

    @(negedge Clock);
    if (e == '0) begin
      check_eq("bad_vector", bus.oBadVector, 1);
      check_eq("bad_no_trig", bus.oTriggerIFU, 0);
      check_eq("bad_busy", bus.oBusy, 0);
      check_eq("bad_entry", bus.oEntryPoint, 0);
      bus.iIFUDone = 1'b0;
      m_ptr = win;
      return;
    end
    check_eq("trigger", bus.oTriggerIFU, 1);
    check_eq("entry", bus.oEntryPoint, e);
    check_eq("no_bad", bus.oBadVector, 0);

    end_c = (done_at <= TO - 1) ? done_at + 1 : TO;
    for (int c = 0; c < end_c; c++) begin
      if (c == abort_at) begin
        #2 Reset = 1'b0;
        #1 check_quiet("reset_async");
        check_eq("reset_state", bus.oDbgState, ST_IDLE);
        check_eq("reset_id", bus.oActiveId, 0);
        check_eq("reset_addr", bus.oIMemAddr, 0);
        @(negedge Clock);
        check_quiet("reset_hold");
        Reset = 1'b1;
        bus.iIFUDone = 1'b0;
        m_ptr = N - 1;
        return;
      end
      bus.iIFUDone = (c == done_at);
      @(negedge Clock);
      if (c + 1 < end_c) begin
        check_eq("run_no_end", {bus.oDone, bus.oTimeout}, 0);
        check_eq("run_entry", bus.oEntryPoint, e);
        check_eq("run_trig_low", bus.oTriggerIFU, 0);
      end
    end
    bus.iIFUDone = 1'b0;
    if (done_at <= TO - 1) begin
      check_eq("done", bus.oDone, g);
      check_eq("done_no_tmo", bus.oTimeout, 0);
    end else begin
      check_eq("timeout", bus.oTimeout, 1);
      check_eq("tmo_no_done", bus.oDone, 0);
    end
    check_eq("end_entry", bus.oEntryPoint, 0);
    check_eq("end_busy", bus.oBusy, 0);
    check_eq("end_state", bus.oDbgState, ST_IDLE);
    m_ptr = win;
  endtask

  task automatic pulse_reset();
    @(negedge Clock);
    Reset = 1'b0;
    @(negedge Clock);
    Reset = 1'b1;
    pending = '0;
    bus.iRequest = '0;
    m_ptr = N - 1;
  endtask

  initial begin
    logic [DW-1:0] d;
    logic [N-1:0] r;
    bus.iRequest    = '0;
    bus.iVectorAddr = '0;
    bus.iIFUDone    = 1'b0;
    pending = '0;
    m_ptr = N - 1;

    #2 check_quiet("por");
    check_eq("por_state", bus.oDbgState, ST_IDLE);
    check_eq("por_id", bus.oActiveId, 0);
    check_eq("por_addr", bus.oIMemAddr, 0);
    @(negedge Clock);
    @(negedge Clock);
    Reset = 1'b1;

    // First job: requester 0, vector at 0x10 pointing to 0x0200.
    run_job(4'b0001, 0, 5, -1, 16'h0010, 64'hDEAD_BEEF_0000_0200);
    @(negedge Clock);
    check_quiet("idle_after_done");

    // All requesters held: order 0,1,2,3,0 from reset, then drain.
    pulse_reset();
    for (int i = 0; i < 5; i++)
      run_job(4'b1111, 1, $urandom_range(0, 3), -1, AW'($urandom), {$urandom, 16'h0, 16'h0100 + 16'(i)});
    while (pending != '0)
      run_job(4'b0000, 0, 1, -1, AW'($urandom), 64'h0000_0000_0000_0404);

    // Bad vector followed by the next pending requester.
    run_job(4'b0110, 0, 2, -1, 16'h0300, 64'hFFFF_FFFF_FFFF_0000);
    run_job(4'b0000, 0, 2, -1, 16'h0308, 64'h0000_0000_0000_0777);

    // Watchdog: no done, done on the expiry cycle, done one cycle before.
    run_job(4'b1000, 0, TO + 5, -1, 16'h0400, 64'h0000_0000_0000_1234);
    run_job(4'b0100, 0, TO - 1, -1, 16'h0410, 64'h0000_0000_0000_2345);
    run_job(4'b0010, 0, TO - 2, -1, 16'h0420, 64'h0000_0000_0000_3456);

    // Reset during RUN, then requester 0 must win over the others.
    run_job(4'b1100, 0, TO + 5, 3, 16'h0500, 64'h0000_0000_0000_5555);
    run_job(4'b0001, 0, 0, -1, 16'h0510, 64'h0000_0000_0000_6666);
    while (pending != '0)
      run_job(4'b0000, 0, 1, -1, AW'($urandom), 64'h0000_0000_0000_0abc);

    for (int i = 0; i < 40; i++) begin
      r = N'($urandom_range(0, (1 << N) - 1));
      if ((pending | r) == '0) r[$urandom_range(0, N - 1)] = 1'b1;
      d = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) d[AW-1:0] = '0;
      run_job(r, $urandom_range(0, 3) == 0, $urandom_range(0, TO + 3), -1, AW'($urandom), d);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
